// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: takes WIDTH-bit words on a valid/ready handshake and
// shifts them out one bit per clock with a data-valid qualifier and frame marker.
module bit_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          LSB_FIRST  = 1'b0,
    parameter int unsigned GAP_CYCLES = 0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data,
    output logic             data_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
    localparam logic [7:0]      GapLast = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic              data_q, data_d;
    logic              data_valid_q, data_valid_d;
    logic              frame_start_q, frame_start_d;
    logic              busy_q, busy_d;
    logic              last_bit;
    logic              accept;

    // shreg holds the bits not yet driven; the outgoing bit sits at the shift end
    function automatic logic next_bit(input logic [WIDTH-1:0] x);
        return LSB_FIRST ? x[0] : x[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] x);
        return LSB_FIRST ? {1'b0, x[WIDTH-1:1]} : {x[WIDTH-2:0], 1'b0};
    endfunction

    always_comb begin
        last_bit = (state_q == StShift) && (bit_cnt_q == LastCnt);
        in_ready = (state_q == StIdle) || ((GAP_CYCLES == 0) && last_bit);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        data_d        = IDLE_LEVEL;
        data_valid_d  = 1'b0;
        frame_start_d = 1'b0;

        unique case (state_q)
            StIdle: ;
            StShift: begin
                if (!last_bit) begin
                    data_d       = next_bit(shreg_q);
                    shreg_d      = shift_out(shreg_q);
                    bit_cnt_d    = bit_cnt_q + 1'b1;
                    data_valid_d = 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    state_d   = StGap;
                    gap_cnt_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // An accepted word overrides everything, giving zero-bubble back-to-back
        if (accept) begin
            state_d       = StShift;
            bit_cnt_d     = '0;
            data_d        = next_bit(in_data);
            shreg_d       = shift_out(in_data);
            data_valid_d  = 1'b1;
            frame_start_d = 1'b1;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            data_q        <= IDLE_LEVEL;
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: three instances cover MSB-first/no-gap,
// a two-cycle gap, and LSB-first ordering.
module tb_bit_serializer;

    logic       clk;
    logic       rst_n;
    logic [7:0] din [3];
    logic [2:0] vin;
    logic [2:0] rdy, dout, dv, fs, bsy;

    logic [63:0] rec_d, rec_v, rec_fs, rec_busy, rec_rdy;
    int n_cmp;
    int n_err;

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_data(din[0]), .in_valid(vin[0]), .in_ready(rdy[0]),
        .data(dout[0]), .data_valid(dv[0]), .frame_start(fs[0]), .busy(bsy[0])
    );

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) u_gap (
        .clk(clk), .rst_n(rst_n), .in_data(din[1]), .in_valid(vin[1]), .in_ready(rdy[1]),
        .data(dout[1]), .data_valid(dv[1]), .frame_start(fs[1]), .busy(bsy[1])
    );

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_data(din[2]), .in_valid(vin[2]), .in_ready(rdy[2]),
        .data(dout[2]), .data_valid(dv[2]), .frame_start(fs[2]), .busy(bsy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_rec();
        rec_d = '0; rec_v = '0; rec_fs = '0; rec_busy = '0; rec_rdy = '0;
    endtask

    task automatic snap(input int k, input int i);
        rec_d[i]    = dout[k];
        rec_v[i]    = dv[k];
        rec_fs[i]   = fs[k];
        rec_busy[i] = bsy[k];
        rec_rdy[i]  = rdy[k];
    endtask

    // Valid bits shifted in arrival order; nbad counts non-idle data while invalid
    task automatic stream(input int n, output logic [31:0] s, output int nv, output int nbad);
        s = '0; nv = 0; nbad = 0;
        for (int i = 0; i < n; i++) begin
            if (rec_v[i]) begin
                s = {s[30:0], rec_d[i]};
                nv++;
            end else if (rec_d[i] != 1'b0) begin
                nbad++;
            end
        end
    endtask

    logic [31:0] s;
    int nv, nbad, hits;

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b1; vin = '0;
        for (int k = 0; k < 3; k++) din[k] = '0;
        clear_rec();

        // Power-on reset
        #2 rst_n = 1'b0;
        #1 check_eq("por_outs", 32'({dout, dv, fs, bsy}), 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        check_eq("por_ready", 32'(rdy), 32'h7);

        // Single word D2, MSB first
        clear_rec();
        @(negedge clk); din[0] = 8'hD2; vin[0] = 1'b1;
        check_eq("single_ready", 32'(rdy[0]), 32'h1);
        @(negedge clk); snap(0, 0); vin[0] = 1'b0;
        for (int i = 1; i < 12; i++) begin @(negedge clk); snap(0, i); end
        stream(12, s, nv, nbad);
        check_eq("single_bits", s, 32'hD2);
        check_eq("single_vmask", 32'(rec_v[11:0]), 32'h0FF);
        check_eq("single_fsmask", 32'(rec_fs[11:0]), 32'h001);
        check_eq("single_busy", 32'(rec_busy[11:0]), 32'h0FF);
        check_eq("single_idle_lvl", 32'(nbad), 32'h0);
        hits = 0;
        for (int i = 0; i < 9; i++)
            if (rec_v[i+:4] == 4'hF && {rec_d[i], rec_d[i+1], rec_d[i+2], rec_d[i+3]} == 4'b1101)
                hits++;
        check_eq("single_1101", 32'(hits), 32'h1);

        // Back-to-back FF then 00, no gap
        clear_rec();
        @(negedge clk); din[0] = 8'hFF; vin[0] = 1'b1;
        @(negedge clk); snap(0, 0); din[0] = 8'h00;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk); snap(0, i);
            if (i == 8) vin[0] = 1'b0;
        end
        stream(20, s, nv, nbad);
        check_eq("b2b_bits", s, 32'hFF00);
        check_eq("b2b_vmask", 32'(rec_v[19:0]), 32'h0FFFF);
        check_eq("b2b_fsmask", 32'(rec_fs[19:0]), 32'h00101);
        check_eq("b2b_ready", 32'(rec_rdy[19:0]), 32'hF8080);

        // Two-cycle gap, A5 then 3C
        clear_rec();
        @(negedge clk); din[1] = 8'hA5; vin[1] = 1'b1;
        @(negedge clk); snap(1, 0); din[1] = 8'h3C;
        for (int i = 1; i < 23; i++) begin
            @(negedge clk); snap(1, i);
            if (i == 11) vin[1] = 1'b0;
        end
        stream(23, s, nv, nbad);
        check_eq("gap_bits", s, 32'hA53C);
        check_eq("gap_vmask", 32'(rec_v[22:0]), 32'h7F8FF);
        check_eq("gap_fsmask", 32'(rec_fs[22:0]), 32'h00801);
        check_eq("gap_busy_idle", 32'(rec_busy[22:0] & ~rec_v[22:0]), 32'h180300);
        check_eq("gap_ready", 32'(rec_rdy[22:0]), 32'h600400);
        check_eq("gap_idle_lvl", 32'(nbad), 32'h0);

        // LSB first, 01, with an in_valid pulse mid-word that must be ignored
        clear_rec();
        @(negedge clk); din[2] = 8'h01; vin[2] = 1'b1;
        @(negedge clk); snap(2, 0); vin[2] = 1'b0;
        for (int i = 1; i < 12; i++) begin
            @(negedge clk); snap(2, i);
            if (i == 3) begin
                din[2] = 8'hFF; vin[2] = 1'b1;
                check_eq("lsb_ready_mid", 32'(rdy[2]), 32'h0);
            end else begin
                vin[2] = 1'b0;
            end
        end
        stream(12, s, nv, nbad);
        check_eq("lsb_bits", s, 32'h80);
        check_eq("lsb_nvalid", 32'(nv), 32'd8);
        check_eq("lsb_fsmask", 32'(rec_fs[11:0]), 32'h001);

        // Reset during bit 4 of F0
        clear_rec();
        @(negedge clk); din[0] = 8'hF0; vin[0] = 1'b1;
        @(negedge clk); snap(0, 0); vin[0] = 1'b0;
        for (int i = 1; i < 4; i++) begin @(negedge clk); snap(0, i); end
        stream(4, s, nv, nbad);
        check_eq("rst_pre_bits", s, 32'hF);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_async_outs", 32'({dout[0], dv[0], fs[0], bsy[0]}), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        check_eq("rst_ready", 32'(rdy[0]), 32'h1);
        clear_rec();
        for (int i = 0; i < 5; i++) begin @(negedge clk); snap(0, i); end
        check_eq("rst_no_tail", 32'(rec_v[4:0] | rec_busy[4:0]), 32'h0);

        clear_rec();
        @(negedge clk); din[0] = 8'h81; vin[0] = 1'b1;
        @(negedge clk); snap(0, 0); vin[0] = 1'b0;
        for (int i = 1; i < 10; i++) begin @(negedge clk); snap(0, i); end
        stream(10, s, nv, nbad);
        check_eq("post_rst_bits", s, 32'h81);
        check_eq("post_rst_vmask", 32'(rec_v[9:0]), 32'h0FF);
        check_eq("post_rst_fsmask", 32'(rec_fs[9:0]), 32'h001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial stage sitting directly upstream of the serial sequence detector. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a single-bit serial line, with a qualifying valid and frame marker. Its serial output drives the detector's data input, so software and benches can inject word-level stimulus.

Parameters:
WIDTH, 8, bits per input word (>=2)
LSB_FIRST, 0, 0 = shift MSB first, 1 = shift LSB first
GAP_CYCLES, 0, idle cycles inserted after each word before the next word may start (0..255)
IDLE_LEVEL, 0, value driven on data whenever data_valid=0

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  WIDTH  parallel word to serialize
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
data  output  1  serial bit out (feeds detector data input)
data_valid  output  1  data carries a live bit
frame_start  output  1  high with the first bit of each word
busy  output  1  high in SHIFT or GAP state

Behaviour:
- Reset (rst_n=0, asynchronous, effective immediately):
  - state=IDLE; shift register and counters cleared.
  - data=IDLE_LEVEL, data_valid=0, frame_start=0, busy=0.
  - in_ready=1 once rst_n deasserts.
- All outputs except in_ready are registered. in_ready is combinational from state/counter only, never from in_valid.
- States:
  - IDLE: in_ready=1. Accept on in_valid&&in_ready at a clock edge: latch in_data, bit_cnt=0 -> SHIFT.
  - SHIFT: one bit per cycle, data_valid=1. The first SHIFT cycle carries frame_start=1; in the remaining WIDTH-1 bit cycles frame_start=0. Bit order is MSB..LSB, or LSB..MSB when LSB_FIRST=1.
  - Last bit (bit_cnt=WIDTH-1):
    - GAP_CYCLES>0: -> GAP.
    - GAP_CYCLES=0: in_ready=1 during this cycle. If a word is accepted, the next cycle is its first bit (zero-bubble back-to-back); otherwise -> IDLE.
  - GAP: data_valid=0, data=IDLE_LEVEL, busy=1, in_ready=0 for exactly GAP_CYCLES cycles -> IDLE.
- Latency: handshake edge at cycle N -> first bit on data/data_valid at cycle N+1. Last bit at N+WIDTH.
- in_ready=0 in SHIFT (except the last bit with GAP_CYCLES=0) and in GAP. in_valid is ignored then; in_data is not sampled, and the upstream holds it.
- Whenever data_valid=0: data=IDLE_LEVEL.
- Reset mid-word or mid-gap: the word in flight is dropped, with no further bits and no partial completion. After deassertion the block restarts in IDLE.
- busy=1 exactly when state is SHIFT or GAP.
- Counter widths: bit_cnt is clog2(WIDTH) bits; the gap counter is 8 bits. Neither wraps beyond its terminal value.

Test Plan:
1. Reset: rst_n=0 mid-simulation, asynchronous to clk -> data=0, data_valid=0, frame_start=0, busy=0 immediately; in_ready=1 after release.
2. Single word 8'hD2, MSB first:
   - Handshake at cycle N -> data = 1,1,0,1,0,0,1,0 at N+1..N+8, data_valid high for exactly 8 cycles, frame_start only at N+1.
   - The downstream detector sees 1101 and pulses detected once.
3. Back-to-back, GAP_CYCLES=0, in_valid held with 8'hFF then 8'h00 -> 16 continuous valid bits (8 ones then 8 zeros), no bubble, frame_start at bits 1 and 9.
4. GAP_CYCLES=2, two words 8'hA5, 8'h3C:
   - Exactly 2 cycles with data_valid=0, busy=1, in_ready=0 between words.
   - The second word's frame_start is at cycle 11 after the first.
5. LSB_FIRST=1, word 8'h01 -> data = 1,0,0,0,0,0,0,0. in_valid pulsed with 8'hFF mid-word is ignored (no extra bits, in_ready=0 at that edge).
6. Reset asserted at bit 4 of 8'hF0 -> data_valid drops immediately, and the remaining bits never appear. The next accepted word 8'h81 serializes correctly from frame_start.
